// File: rtl/seq_player_16x4.sv
// seq_player_16x4: plays RAM addresses 0..limite onto leds, HOLD_CYCLES cycles each.
// Define PLAYER_GAP_EN to follow every shown value with GAP_CYCLES blank cycles.
module seq_player_16x4 #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] mem_dado,
    output logic [3:0] mem_endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto
);
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
`ifdef PLAYER_GAP_EN
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHOW, GAP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHOW, DONE} state_t;
`endif
    state_t        state_q;
    logic [3:0]    addr_q, lim_q, led_q, leds_q;
    logic [CW-1:0] cnt_q;
    logic          pronto_q;
    assign mem_endereco = addr_q;
    assign leds = leds_q;
    assign pronto = pronto_q;
    assign ocupado = (state_q != IDLE);
    // leds and pronto are registered, so they trail the state by one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            lim_q    <= '0;
            led_q    <= '0;
            cnt_q    <= '0;
            leds_q   <= '0;
            pronto_q <= 1'b0;
        end else begin
            leds_q   <= (state_q == SHOW) ? led_q : 4'b0000;
            pronto_q <= (state_q == DONE);
            case (state_q)
                IDLE: if (iniciar) begin
                    lim_q   <= limite;
                    addr_q  <= '0;
                    state_q <= FETCH;
                end
                FETCH: state_q <= LOAD;
                LOAD: begin
                    led_q   <= mem_dado;
                    cnt_q   <= '0;
                    state_q <= SHOW;
                end
                SHOW: if (cnt_q == HOLD_LAST) begin
`ifdef PLAYER_GAP_EN
                    cnt_q   <= '0;
                    state_q <= GAP;
`else
                    if (addr_q == lim_q) state_q <= DONE;
                    else begin
                        addr_q  <= addr_q + 4'd1;
                        state_q <= FETCH;
                    end
`endif
                end else cnt_q <= cnt_q + 1'b1;
`ifdef PLAYER_GAP_EN
                GAP: if (cnt_q == GAP_LAST) begin
                    if (addr_q == lim_q) state_q <= DONE;
                    else begin
                        addr_q  <= addr_q + 4'd1;
                        state_q <= FETCH;
                    end
                end else cnt_q <= cnt_q + 1'b1;
`endif
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_player_16x4.sv
// tb_seq_player_16x4: random playbacks against a timing model built from element period arithmetic.
module tb_seq_player_16x4;
    localparam int HOLD = 4;
    localparam int GAP  = 2;
`ifdef PLAYER_GAP_EN
    localparam int P = 2 + HOLD + GAP;
`else
    localparam int P = 2 + HOLD;
`endif
    logic       clock = 1'b0, reset = 1'b1, iniciar = 1'b0;
    logic [3:0] limite = 4'd0, mem_dado, mem_endereco, leds;
    logic       ocupado, pronto;
    logic [3:0] ram [16];
    int         n_cmp = 0, n_err = 0;

    seq_player_16x4 #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .limite(limite),
        .mem_dado(mem_dado), .mem_endereco(mem_endereco), .leds(leds),
        .ocupado(ocupado), .pronto(pronto)
    );

    always #5 clock = ~clock;
    always_ff @(posedge clock) mem_dado <= ram[mem_endereco];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // k = cycles since the start edge; element j is visible during k in [j*P+3, j*P+2+HOLD]
    function automatic logic [3:0] exp_leds(input int k, input int n);
        if (k < 3) return 4'd0;
        if ((k - 3) / P < n && (k - 3) % P < HOLD) return ram[(k - 3) / P];
        return 4'd0;
    endfunction

    task automatic start(input int l);
        iniciar = 1'b1;
        limite = 4'(l);
    endtask

    task automatic play(input int n, input int abort_k, input bit hold);
        int last = n * P;
        for (int k = 0; k <= last + 1; k++) begin
            @(negedge clock);
            check("leds", 8'(leds), 8'(exp_leds(k, n)));
            check("addr", 8'(mem_endereco), 8'((k / P < n - 1) ? k / P : n - 1));
            check("ocupado", 8'(ocupado), 8'(k <= last));
            check("pronto", 8'(pronto), 8'(k == last + 1));
            if (k == abort_k) begin
                reset = 1'b1;
                iniciar = 1'($urandom);
                @(negedge clock);
                check("rst_leds", 8'(leds), 8'd0);
                check("rst_ocupado", 8'(ocupado), 8'd0);
                check("rst_addr", 8'(mem_endereco), 8'd0);
                check("rst_pronto", 8'(pronto), 8'd0);
                reset = 1'b0;
                iniciar = 1'b0;
                @(negedge clock);
                check("post_rst_pronto", 8'(pronto), 8'd0);
                check("post_rst_ocupado", 8'(ocupado), 8'd0);
                return;
            end
            iniciar = hold ? 1'b1 : (k <= last) ? 1'($urandom) : 1'b0;
            limite = 4'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 4'(1 << (i % 4));
        repeat (3) @(negedge clock);
        check("reset_leds", 8'(leds), 8'd0);
        check("reset_addr", 8'(mem_endereco), 8'd0);
        check("reset_ocupado", 8'(ocupado), 8'd0);
        check("reset_pronto", 8'(pronto), 8'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ocupado", 8'(ocupado), 8'd0);
        start(0);  play(1, -1, 1'b0);
        start(3);  play(4, -1, 1'b0);
        start(15); play(16, -1, 1'b0);
        start(5);  play(6, 2 * P + 4, 1'b0);
        start(2);  play(3, -1, 1'b0);
        start(1);  play(2, -1, 1'b1);
        start(2);  play(3, -1, 1'b1);
        start(0);  play(1, -1, 1'b0);
        repeat (24) begin
            int l;
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < 16; i++) ram[i] = 4'($urandom);
            l = $urandom_range(0, 15);
            start(l);
            play(l + 1, ($urandom_range(0, 4) == 0) ? $urandom_range(0, (l + 1) * P) : -1, 1'b0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
